// File: rtl/boot_pkg.sv
// Shared types and descriptor layout for the boot loader controller.
package boot_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      S_IDLE,
      S_ROM_RD,
      S_DECODE,
      S_MEM_RD,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_e;

   // Descriptor target codes
   typedef enum logic [1:0] {
      TGT_END = 2'b00,
      TGT_IM  = 2'b01,
      TGT_DM  = 2'b10,
      TGT_ILL = 2'b11
   } target_e;

   // Descriptor field layout
   localparam int unsigned DESC_W  = 36;
   localparam int unsigned TGT_MSB = 35;
   localparam int unsigned TGT_LSB = 34;
   localparam int unsigned SRC_MSB = 33;
   localparam int unsigned SRC_LSB = 20;
   localparam int unsigned DST_MSB = 19;
   localparam int unsigned DST_LSB = 10;
   localparam int unsigned CNT_MSB = 9;
   localparam int unsigned CNT_LSB = 0;

   localparam int unsigned SRC_W = SRC_MSB - SRC_LSB + 1;
   localparam int unsigned DST_W = DST_MSB - DST_LSB + 1;
   localparam int unsigned CNT_W = CNT_MSB - CNT_LSB + 1;

   function automatic target_e desc_target(input logic [DESC_W-1:0] d);
      return target_e'(d[TGT_MSB:TGT_LSB]);
   endfunction

   function automatic logic [SRC_W-1:0] desc_src(input logic [DESC_W-1:0] d);
      return d[SRC_MSB:SRC_LSB];
   endfunction

   function automatic logic [DST_W-1:0] desc_dst(input logic [DESC_W-1:0] d);
      return d[DST_MSB:DST_LSB];
   endfunction

   function automatic logic [CNT_W-1:0] desc_cnt(input logic [DESC_W-1:0] d);
      return d[CNT_MSB:CNT_LSB];
   endfunction

endpackage

// File: rtl/boot_xfer.sv
// Word-copy datapath: source/destination/count registers and the
// MEM read / IM-or-DM write strobes for one descriptor's word loop.
module boot_xfer
   import boot_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [MEM_AW-1:0] src_i,
   input  logic [DST_W-1:0]  dst_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              dm_i,
   input  logic              rd_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              last_o,
   output logic              mem_en_o,
   output logic              mem_read_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic              im_enable_o,
   output logic              im_write_o,
   output logic [9:0]        im_address_o,
   output logic [DATA_W-1:0] im_in_o,
   output logic              dm_enable_o,
   output logic              dm_write_o,
   output logic [14:0]       dm_address_o,
   output logic [DATA_W-1:0] dm_in_o
);

   logic [MEM_AW-1:0] src_q, src_d;
   logic [DST_W-1:0]  dst_q, dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dm_q,  dm_d;

   // Transfer registers; async clear drops any interrupted copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q <= '0;
         dst_q <= '0;
         cnt_q <= '0;
         dm_q  <= 1'b0;
      end else begin
         src_q <= src_d;
         dst_q <= dst_d;
         cnt_q <= cnt_d;
         dm_q  <= dm_d;
      end
   end

   // Load on descriptor decode, step after each written word (addresses wrap freely)
   always_comb begin
      src_d = src_q;
      dst_d = dst_q;
      cnt_d = cnt_q;
      dm_d  = dm_q;
      if (load_i) begin
         src_d = src_i;
         dst_d = dst_i;
         cnt_d = cnt_i;
         dm_d  = dm_i;
      end else if (wr_i) begin
         src_d = src_q + 1'b1;
         dst_d = dst_q + 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Bus strobes, gated so every output is zero outside its phase
   always_comb begin
      last_o       = (cnt_q == CNT_W'(1));
      mem_en_o     = rd_i;
      mem_read_o   = rd_i;
      mem_addr_o   = rd_i ? src_q : '0;
      im_enable_o  = wr_i & ~dm_q;
      im_write_o   = wr_i & ~dm_q;
      im_address_o = (wr_i & ~dm_q) ? dst_q : '0;
      im_in_o      = (wr_i & ~dm_q) ? mem_data_i : '0;
      dm_enable_o  = wr_i & dm_q;
      dm_write_o   = wr_i & dm_q;
      dm_address_o = (wr_i & dm_q) ? {5'b0, dst_q} : '0;
      dm_in_o      = (wr_i & dm_q) ? mem_data_i : '0;
   end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: walks a descriptor ROM and copies word blocks from backing
// memory into instruction or data memory, then releases the CPU.
module boot_loader_ctrl
   import boot_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ROM_AW = 8,
   parameter int unsigned MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              system_enable,
   output logic              rom_enable,
   output logic              rom_read,
   output logic [ROM_AW-1:0] rom_address,
   input  logic [35:0]       rom_out,
   output logic              MEM_en,
   output logic              MEM_read,
   output logic              MEM_write,
   output logic [MEM_AW-1:0] MEM_addr,
   input  logic [DATA_W-1:0] MEM_data,
   output logic              IM_enable,
   output logic              IM_write,
   output logic              IM_read,
   output logic [9:0]        IM_address,
   output logic [DATA_W-1:0] IM_in,
   output logic              DM_enable,
   output logic              DM_write,
   output logic              DM_read,
   output logic [14:0]       DM_address,
   output logic [DATA_W-1:0] DM_in,
   output logic              boot_done,
   output logic              boot_err,
   output logic [15:0]       words_copied
);

   state_e            state_q, state_d;
   logic [ROM_AW-1:0] ptr_q, ptr_d;
   logic [15:0]       words_q, words_d;

   logic    xfer_load, xfer_rd, xfer_wr, xfer_last;
   target_e tgt;

   assign tgt = desc_target(rom_out);

   // State, descriptor pointer and copied-word counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         words_q <= words_d;
      end
   end

   // Next-state and control; moving past the last ROM entry is a missing terminator
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      words_d     = words_q;
      rom_enable  = 1'b0;
      rom_read    = 1'b0;
      rom_address = '0;
      xfer_load   = 1'b0;
      xfer_rd     = 1'b0;
      xfer_wr     = 1'b0;
      boot_done   = 1'b0;
      boot_err    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (system_enable) state_d = S_ROM_RD;
         end
         S_ROM_RD: begin
            rom_enable  = 1'b1;
            rom_read    = 1'b1;
            rom_address = ptr_q;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            if (tgt == TGT_END) begin
               state_d = S_DONE;
            end else if (tgt == TGT_ILL) begin
               state_d = S_ERROR;
            end else if (desc_cnt(rom_out) == '0) begin
               if (ptr_q == '1) begin
                  state_d = S_ERROR;
               end else begin
                  ptr_d   = ptr_q + 1'b1;
                  state_d = S_ROM_RD;
               end
            end else begin
               xfer_load = 1'b1;
               state_d   = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            xfer_rd = 1'b1;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            xfer_wr = 1'b1;
            if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
            if (!xfer_last) begin
               state_d = S_MEM_RD;
            end else if (ptr_q == '1) begin
               state_d = S_ERROR;
            end else begin
               ptr_d   = ptr_q + 1'b1;
               state_d = S_ROM_RD;
            end
         end
         S_DONE:  boot_done = 1'b1;
         S_ERROR: boot_err  = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   assign words_copied = words_q;
   assign MEM_write    = 1'b0;
   assign IM_read      = 1'b0;
   assign DM_read      = 1'b0;

   boot_xfer #(
      .DATA_W (DATA_W),
      .MEM_AW (MEM_AW)
   ) u_xfer (
      .clk          (clk),
      .rst          (rst),
      .load_i       (xfer_load),
      .src_i        (MEM_AW'(desc_src(rom_out))),
      .dst_i        (desc_dst(rom_out)),
      .cnt_i        (desc_cnt(rom_out)),
      .dm_i         (tgt == TGT_DM),
      .rd_i         (xfer_rd),
      .wr_i         (xfer_wr),
      .mem_data_i   (MEM_data),
      .last_o       (xfer_last),
      .mem_en_o     (MEM_en),
      .mem_read_o   (MEM_read),
      .mem_addr_o   (MEM_addr),
      .im_enable_o  (IM_enable),
      .im_write_o   (IM_write),
      .im_address_o (IM_address),
      .im_in_o      (IM_in),
      .dm_enable_o  (DM_enable),
      .dm_write_o   (DM_write),
      .dm_address_o (DM_address),
      .dm_in_o      (DM_in)
   );

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with ROM/MEM models and IM/DM capture.
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        system_enable = 1'b0;
   logic        rom_enable, rom_read;
   logic [7:0]  rom_address;
   logic [35:0] rom_out = '0;
   logic        MEM_en, MEM_read, MEM_write;
   logic [13:0] MEM_addr;
   logic [31:0] MEM_data = '0;
   logic        IM_enable, IM_write, IM_read;
   logic [9:0]  IM_address;
   logic [31:0] IM_in;
   logic        DM_enable, DM_write, DM_read;
   logic [14:0] DM_address;
   logic [31:0] DM_in;
   logic        boot_done, boot_err;
   logic [15:0] words_copied;

   boot_loader_ctrl #(.DATA_W(32), .ROM_AW(8), .MEM_AW(14)) dut (
      .clk(clk), .rst(rst), .system_enable(system_enable),
      .rom_enable(rom_enable), .rom_read(rom_read), .rom_address(rom_address), .rom_out(rom_out),
      .MEM_en(MEM_en), .MEM_read(MEM_read), .MEM_write(MEM_write), .MEM_addr(MEM_addr), .MEM_data(MEM_data),
      .IM_enable(IM_enable), .IM_write(IM_write), .IM_read(IM_read), .IM_address(IM_address), .IM_in(IM_in),
      .DM_enable(DM_enable), .DM_write(DM_write), .DM_read(DM_read), .DM_address(DM_address), .DM_in(DM_in),
      .boot_done(boot_done), .boot_err(boot_err), .words_copied(words_copied)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [35:0] rom [256];
   logic [31:0] im_mem [1024];
   logic [31:0] dm_mem [1024];
   int im_wr_cnt, dm_wr_cnt, mem_rd_cnt, rom_rd_cnt;
   bit overlap_seen, illegal_seen;

   function automatic logic [31:0] memval(input int unsigned i);
      return 32'hC0DE_0000 ^ (i * 32'h0001_0003);
   endfunction

   // Synchronous ROM and MEM models, plus write capture and bus monitors
   always @(posedge clk) begin
      if (rom_enable && rom_read) begin
         rom_out <= rom[rom_address];
         rom_rd_cnt++;
      end
      if (MEM_en && MEM_read) begin
         MEM_data <= memval(int'(MEM_addr));
         mem_rd_cnt++;
      end
      if (IM_enable && IM_write) begin
         im_mem[IM_address] = IM_in;
         im_wr_cnt++;
      end
      if (DM_enable && DM_write) begin
         dm_mem[DM_address[9:0]] = DM_in;
         dm_wr_cnt++;
         if (DM_address[14:10] != 5'd0) illegal_seen = 1'b1;
      end
      if (IM_write && DM_write) overlap_seen = 1'b1;
      if (MEM_write || IM_read || DM_read) illegal_seen = 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      system_enable = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         im_mem[i] = 32'hDEAD_BEEF;
         dm_mem[i] = 32'hDEAD_BEEF;
      end
      im_wr_cnt = 0; dm_wr_cnt = 0; mem_rd_cnt = 0; rom_rd_cnt = 0;
      overlap_seen = 1'b0; illegal_seen = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_rom(input logic [35:0] d0, input logic [35:0] d1, input logic [35:0] d2);
      for (int i = 0; i < 256; i++) rom[i] = '0;
      rom[0] = d0; rom[1] = d1; rom[2] = d2;
   endtask

   // Returns number of rising edges from the start request until done/err is seen
   task automatic run_boot(output int ncyc);
      @(negedge clk);
      system_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      system_enable = 1'b0;
      ncyc = 1;
      while (!boot_done && !boot_err && ncyc < 5000) begin
         @(posedge clk);
         @(negedge clk);
         ncyc++;
      end
      if (ncyc >= 5000) check("boot_timeout", 64'(ncyc), 64'd0);
   endtask

   // Walk descriptors and verify every copied word landed where expected
   task automatic check_copies(input string name, input logic [35:0] d0,
                               input logic [35:0] d1, input logic [35:0] d2);
      logic [35:0] ds [3];
      int bad = 0;
      int exp_im = 0;
      int exp_dm = 0;
      ds[0] = d0; ds[1] = d1; ds[2] = d2;
      for (int j = 0; j < 3; j++) begin
         logic [1:0] t;
         int unsigned src, dst, n;
         t   = ds[j][35:34];
         src = int'(ds[j][33:20]);
         dst = int'(ds[j][19:10]);
         n   = int'(ds[j][9:0]);
         if (t == 2'b00 || t == 2'b11) break;
         for (int unsigned k = 0; k < n; k++) begin
            int unsigned a;
            a = (dst + k) % 1024;
            if (t == 2'b01) begin
               if (im_mem[a] !== memval((src + k) % 16384)) bad++;
               exp_im++;
            end else begin
               if (dm_mem[a] !== memval((src + k) % 16384)) bad++;
               exp_dm++;
            end
         end
      end
      check({name, "_data"}, 64'(bad), 64'd0);
      check({name, "_im_writes"}, 64'(im_wr_cnt), 64'(exp_im));
      check({name, "_dm_writes"}, 64'(dm_wr_cnt), 64'(exp_dm));
   endtask

   typedef struct {
      string       name;
      logic [35:0] d0, d1, d2;
      logic        exp_done, exp_err;
      logic [15:0] exp_words;
      int          exp_cycles;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int n;
      int wait_cyc;
      int rom_before;

      vecs[0] = '{"im4",      {2'b01, 14'd0,     10'd128,  10'd4},  36'd0,
                  36'd0, 1'b1, 1'b0, 16'd4,  12};
      vecs[1] = '{"im2_dm3",  {2'b01, 14'd10,    10'd5,    10'd2},
                  {2'b10, 14'd20, 10'd0, 10'd3}, 36'd0, 1'b1, 1'b0, 16'd5, 16};
      vecs[2] = '{"n_zero",   {2'b01, 14'd0,     10'd0,    10'd0},  36'd0,
                  36'd0, 1'b1, 1'b0, 16'd0,  4};
      vecs[3] = '{"illegal",  {2'b11, 14'd3,     10'd3,    10'd3},  36'd0,
                  36'd0, 1'b0, 1'b1, 16'd0,  2};
      vecs[4] = '{"src_wrap", {2'b10, 14'd16383, 10'd7,    10'd2},  36'd0,
                  36'd0, 1'b1, 1'b0, 16'd2,  8};
      vecs[5] = '{"dst_wrap", {2'b01, 14'd100,   10'd1000, 10'd30}, 36'd0,
                  36'd0, 1'b1, 1'b0, 16'd30, 64};

      // Reset state
      load_rom('0, '0, '0);
      do_reset();
      check("rst_done",  64'(boot_done), 64'd0);
      check("rst_err",   64'(boot_err), 64'd0);
      check("rst_words", 64'(words_copied), 64'd0);
      check("rst_strobes", 64'({rom_enable, MEM_en, IM_enable, DM_enable}), 64'd0);

      // Table-driven descriptor scenarios
      for (int v = 0; v < 6; v++) begin
         load_rom(vecs[v].d0, vecs[v].d1, vecs[v].d2);
         do_reset();
         run_boot(n);
         check({vecs[v].name, "_done"},   64'(boot_done), 64'(vecs[v].exp_done));
         check({vecs[v].name, "_err"},    64'(boot_err), 64'(vecs[v].exp_err));
         check({vecs[v].name, "_words"},  64'(words_copied), 64'(vecs[v].exp_words));
         check({vecs[v].name, "_cycles"}, 64'(n - 1), 64'(vecs[v].exp_cycles));
         check({vecs[v].name, "_memrd"},  64'(mem_rd_cnt), 64'(vecs[v].exp_words));
         check({vecs[v].name, "_overlap"}, 64'(overlap_seen), 64'd0);
         check({vecs[v].name, "_illegal"}, 64'(illegal_seen), 64'd0);
         check_copies(vecs[v].name, vecs[v].d0, vecs[v].d1, vecs[v].d2);
      end

      // Error is terminal: further start requests do nothing
      load_rom({2'b11, 14'd0, 10'd0, 10'd1}, '0, '0);
      do_reset();
      run_boot(n);
      rom_before = rom_rd_cnt;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         system_enable = ~system_enable;
      end
      @(negedge clk);
      system_enable = 1'b0;
      @(negedge clk);
      check("err_sticky_err",  64'(boot_err), 64'd1);
      check("err_sticky_done", 64'(boot_done), 64'd0);
      check("err_sticky_rom",  64'(rom_rd_cnt), 64'(rom_before));
      check("err_sticky_wr",   64'(im_wr_cnt + dm_wr_cnt), 64'd0);

      // No terminator anywhere: pointer runs off the end of the ROM
      for (int i = 0; i < 256; i++) rom[i] = {2'b01, 14'd0, 10'd0, 10'd0};
      do_reset();
      run_boot(n);
      check("noterm_err",    64'(boot_err), 64'd1);
      check("noterm_done",   64'(boot_done), 64'd0);
      check("noterm_cycles", 64'(n - 1), 64'd512);
      check("noterm_romrd",  64'(rom_rd_cnt), 64'd256);

      // Reset during the third write of a 4-word copy, then a clean restart
      load_rom(vecs[0].d0, '0, '0);
      do_reset();
      @(negedge clk);
      system_enable = 1'b1;
      @(negedge clk);
      system_enable = 1'b0;
      wait_cyc = 0;
      while (!(IM_write && im_wr_cnt == 2) && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("midrst_reached_w3", 64'(wait_cyc < 100), 64'd1);
      check("midrst_words_before", 64'(words_copied), 64'd2);
      rst = 1'b1;
      #1;
      check("midrst_strobes", 64'({rom_enable, MEM_en, MEM_read, IM_enable, IM_write, DM_enable, DM_write}), 64'd0);
      check("midrst_words", 64'(words_copied), 64'd0);
      check("midrst_flags", 64'({boot_done, boot_err}), 64'd0);
      check("midrst_imdata", 64'({IM_address, IM_in}), 64'd0);
      do_reset();
      run_boot(n);
      check("restart_done",   64'(boot_done), 64'd1);
      check("restart_words",  64'(words_copied), 64'd4);
      check("restart_cycles", 64'(n - 1), 64'd12);
      check_copies("restart", vecs[0].d0, '0, '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the IM/DM/MEM word width.
REQ-002 SHALL have parameter ROM_AW, default 8, meaning the descriptor ROM address width.
REQ-003 SHALL have parameter MEM_AW, default 14, meaning the backing-memory address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port system_enable, input, 1, the boot start request.
REQ-007 SHALL have ports rom_enable and rom_read, output, 1 each; rom_address, output, ROM_AW; rom_out, input, 36, the descriptor.
REQ-008 SHALL have ports MEM_en and MEM_read, output, 1 each; MEM_write, output, 1, tied 0; MEM_addr, output, MEM_AW; MEM_data, input, DATA_W.
REQ-009 SHALL have ports IM_enable and IM_write, output, 1 each; IM_read, output, 1, tied 0; IM_address, output, 10; IM_in, output, DATA_W.
REQ-010 SHALL have ports DM_enable and DM_write, output, 1 each; DM_read, output, 1, tied 0; DM_address, output, 15; DM_in, output, DATA_W.
REQ-011 SHALL have ports boot_done, output, 1 (CPU release); boot_err, output, 1; words_copied, output, 16.

Function
REQ-012 Descriptor fields SHALL be: [35:34] target (00 end, 01 IM, 10 DM, 11 illegal); [33:20] MEM source address; [19:10] destination address; [9:0] word count N.
REQ-013 ROM and MEM reads SHALL be synchronous: read issued in cycle k, data valid in cycle k+1.
REQ-014 FSM states SHALL be IDLE, ROM_RD, DECODE, MEM_RD, WRITE, DONE, ERROR.
REQ-015 IDLE->ROM_RD when system_enable=1; system_enable SHALL be ignored outside IDLE.
REQ-016 ROM_RD: rom_enable=rom_read=1, rom_address=descriptor pointer; next state DECODE.
REQ-017 DECODE: latch rom_out; target 00 -> DONE; 11 -> ERROR; N=0 -> pointer+1, ROM_RD; else load src/dst/count, go MEM_RD.
REQ-018 MEM_RD: MEM_en=MEM_read=1, MEM_addr=src; next state WRITE.
REQ-019 WRITE: drive MEM_data to IM_in (IM_enable=IM_write=1, IM_address=dst) or DM_in (DM_enable=DM_write=1, DM_address=zero-extended dst); src+1, dst+1, count-1, words_copied+1.
REQ-020 WRITE->MEM_RD if remaining count>0, else pointer+1 and ROM_RD.
REQ-021 Throughput SHALL be 2 cycles/word; overhead 2 cycles/descriptor including terminator.
REQ-022 src SHALL wrap modulo 2^MEM_AW and dst modulo 2^10 without error.
REQ-023 Pointer wrap past 2^ROM_AW-1 without terminator SHALL go to ERROR.
REQ-024 words_copied SHALL saturate at 16'hFFFF.
REQ-025 DONE and ERROR SHALL be terminal until rst; boot_done=1 in DONE only, boot_err=1 in ERROR only.
REQ-026 All enables/strobes SHALL be 0 in IDLE, DECODE, DONE, ERROR; never IM and DM write in the same cycle.

Reset
REQ-027 rst SHALL immediately force IDLE, pointer=0, all outputs 0, words_copied=0, including mid-copy; interrupted copy is not resumed.

Structure
REQ-028 Package boot_pkg SHALL hold the state enum, target codes and descriptor field positions.
REQ-029 One sub-module boot_xfer (MEM_RD/WRITE word loop with src/dst/count registers) is natural; DECODE/ROM sequencing stays in boot_loader_ctrl.

Verification
REQ-030 ROM[0]={01,src 0,dst 128,N 4}, ROM[1]=end; MEM[0..3]=A,B,C,D -> IM[128..131]=A..D, boot_done after 12 non-IDLE cycles, words_copied=4.
REQ-031 ROM[0]=IM N=2 from src 10, ROM[1]=DM N=3 src 20 dst 0, ROM[2]=end -> IM and DM loaded, IM/DM strobes never overlap, words_copied=5.
REQ-032 ROM[0]={01,N 0}, ROM[1]=end -> no MEM/IM activity, boot_done=1, words_copied=0.
REQ-033 ROM[0] target 11 -> boot_err=1, boot_done=0, no writes; system_enable toggled afterwards has no effect.
REQ-034 src=16383, N=2 -> reads MEM[16383] then MEM[0]; no terminator in all 256 ROM entries -> boot_err=1.
REQ-035 rst asserted during third WRITE of N=4 copy -> outputs 0 within same cycle, IDLE; restart copies all 4 words.
